// File: rtl/alu_exec_unit.sv
// alu_exec_unit: single-issue ALU execution stage with a bit-serial shifter.
//
// Non-shift operations and zero-amount shifts finish one cycle after accept.
// Shifts with a non-zero amount n move one bit per cycle, so their result
// appears n+1 cycles after accept.
//
// Handshake semantics, both sides:
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   The producer holds its payload while valid=1 and ready=0.
//   Upstream (InValid/InReady): InReady is 1 in IDLE, and in DONE when the
//   current result is being taken (OutReady=1), which gives back-to-back issue.
//   Downstream (OutValid/OutReady): Result/Zero/IllegalOp stay stable while
//   OutValid=1 and OutReady=0.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   InValid / InReady       operation handshake
//   ALUControl              4-bit operation code
//   SrcA                    operand A; SrcA[4:0] is the variable shift amount
//   SrcB                    operand B; the value moved by every shift
//   Shamt                   immediate shift amount (SLLI only)
//   OutValid / OutReady     result handshake
//   Result, Zero, IllegalOp registered result and flags
//   dbg_state               current FSM state (IDLE=0, SHIFT=1, DONE=2)
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [4:0]       Shamt,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             IllegalOp,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SH_LL = 2'd0,  // logical left, zero fill
    SH_RL = 2'd1,  // logical right, zero fill
    SH_RA = 2'd2   // arithmetic right, sign fill
  } shdir_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [4:0]       cnt_q, cnt_d;
  shdir_t           dir_q, dir_d;

  logic             accept;
  logic [WIDTH-1:0] alu_res;
  logic             is_shift;
  logic             is_illegal;
  logic [4:0]       amt;
  shdir_t           dir;
  logic             slt;
  logic [WIDTH-1:0] shreg_step;

  assign InReady   = (state_q == IDLE) || ((state_q == DONE) && OutReady);
  assign accept    = InValid && InReady;
  assign OutValid  = (state_q == DONE);
  assign Result    = result_q;
  assign IllegalOp = illegal_q;
  // Zero looks only at the registered result and is qualified by OutValid,
  // so it reads 0 out of reset and while a shift is still in flight.
  assign Zero      = OutValid && (result_q == '0);
  assign dbg_state = state_q;

  assign slt = ($signed(SrcA) < $signed(SrcB));

  // Operation decode for the operands on the input bus.
  always_comb begin
    alu_res    = '0;
    is_shift   = 1'b0;
    is_illegal = 1'b0;
    amt        = '0;
    dir        = SH_LL;
    case (ALUControl)
      4'b0000: alu_res = SrcA & SrcB;
      4'b0001: alu_res = SrcA | SrcB;
      4'b0010: alu_res = SrcA + SrcB;
      4'b0110: alu_res = SrcA - SrcB;
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, slt};
      4'b0101: alu_res = ~(SrcA | SrcB);
      4'b0100: begin is_shift = 1'b1; amt = Shamt;     dir = SH_LL; end
      4'b1000: begin is_shift = 1'b1; amt = SrcA[4:0]; dir = SH_LL; end
      4'b1001: begin is_shift = 1'b1; amt = SrcA[4:0]; dir = SH_RL; end
      4'b1010: begin is_shift = 1'b1; amt = SrcA[4:0]; dir = SH_RA; end
      default: is_illegal = 1'b1;  // result stays 0
    endcase
  end

  // One-bit step of the serial shifter.
  always_comb begin
    shreg_step = shreg_q;
    case (dir_q)
      SH_LL:   shreg_step = {shreg_q[WIDTH-2:0], 1'b0};
      SH_RL:   shreg_step = {1'b0, shreg_q[WIDTH-1:1]};
      SH_RA:   shreg_step = {shreg_q[WIDTH-1], shreg_q[WIDTH-1:1]};
      default: shreg_step = shreg_q;
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;

    case (state_q)
      SHIFT: begin
        shreg_d = shreg_step;
        cnt_d   = cnt_q - 5'd1;
        // The last step lands directly in the result register.
        if (cnt_q == 5'd1) begin
          state_d   = DONE;
          result_d  = shreg_step;
          illegal_d = 1'b0;
        end
      end
      DONE: begin
        if (OutReady && !InValid) state_d = IDLE;
      end
      default: ;
    endcase

    // Accept is only possible from IDLE or a draining DONE, never from SHIFT.
    if (accept) begin
      if (is_shift && (amt != 5'd0)) begin
        state_d   = SHIFT;
        shreg_d   = SrcB;
        cnt_d     = amt;
        dir_d     = dir;
        illegal_d = 1'b0;
      end else begin
        state_d   = DONE;
        result_d  = is_shift ? SrcB : alu_res;
        illegal_d = is_illegal;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      result_q  <= '0;
      illegal_q <= 1'b0;
      shreg_q   <= '0;
      cnt_q     <= '0;
      dir_q     <= SH_LL;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Testbench for alu_exec_unit: directed vectors, expected responses queued
// at accept time and checked by an output monitor.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [3:0]  ALUControl = 4'd0;
  logic [31:0] SrcA = 32'd0;
  logic [31:0] SrcB = 32'd0;
  logic [4:0]  Shamt = 5'd0;
  logic        OutValid;
  logic        OutReady = 1'b1;
  logic [31:0] Result;
  logic        Zero;
  logic        IllegalOp;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [33:0] exp_q[$];  // {Result, Zero, IllegalOp}
  logic [33:0] mon_e;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .InValid(InValid), .InReady(InReady),
    .ALUControl(ALUControl), .SrcA(SrcA), .SrcB(SrcB), .Shamt(Shamt),
    .OutValid(OutValid), .OutReady(OutReady),
    .Result(Result), .Zero(Zero), .IllegalOp(IllegalOp),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required completion in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Presents an operation and holds it until accepted. Called just after a
  // rising edge; returns just after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] sh, input logic [31:0] er, input logic ei,
                      output int acc, output int stalls);
    bit got = 0;
    stalls = 0;
    ALUControl = op; SrcA = a; SrcB = b; Shamt = sh; InValid = 1'b1;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (InReady) begin
        got = 1;
        exp_q.push_back({er, (er == 32'd0), ei});
      end else begin
        stalls++;
      end
      @(posedge clk); #1;
    end
    InValid = 1'b0;
    acc = cyc;
    check("accept", {31'd0, got}, 32'd1);
  endtask

  // Waits for OutValid; latency 1 means valid in the cycle right after accept.
  task automatic wait_valid(input int acc, output int lat, output int lowready);
    bit seen = 0;
    lat = 0; lowready = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (OutValid) begin
        seen = 1;
        lat = cyc - acc + 1;
      end else if (!InReady) begin
        lowready++;
      end
      @(posedge clk); #1;
    end
    check("out_valid_seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input logic [31:0] er,
                        input logic ei, input int exp_lat);
    int acc, stalls, lat, low;
    send(op, a, b, sh, er, ei, acc, stalls);
    wait_valid(acc, lat, low);
    check({name, "_latency"}, lat, exp_lat);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && OutValid && OutReady) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got Result %h, required no output", Result);
      end else begin
        mon_e = exp_q.pop_front();
        check("result", Result, mon_e[33:2]);
        check("zero", {31'd0, Zero}, {31'd0, mon_e[1]});
        check("illegal", {31'd0, IllegalOp}, {31'd0, mon_e[0]});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int acc, acc2, stalls, lat, low, vcount;

    // Reset state, checked while reset is held.
    #1;
    check("rst_outvalid", {31'd0, OutValid}, 32'd0);
    check("rst_result", Result, 32'd0);
    check("rst_zero", {31'd0, Zero}, 32'd0);
    check("rst_illegal", {31'd0, IllegalOp}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("inready_after_reset", {31'd0, InReady}, 32'd1);
    @(posedge clk); #1;

    // Single-cycle operations.
    run_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 1'b0, 1);
    run_op("slt_neg",  4'b0111, 32'hFFFF_FFFE, 32'h1, 5'd0, 32'h1, 1'b0, 1);
    run_op("slt_pos",  4'b0111, 32'h1, 32'hFFFF_FFFE, 5'd0, 32'h0, 1'b0, 1);
    run_op("sub_eq",   4'b0110, 32'h5, 32'h5, 5'd0, 32'h0, 1'b0, 1);
    run_op("and",      4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0, 32'h00F0_1200, 1'b0, 1);
    run_op("or",       4'b0001, 32'h0000_00F0, 32'h0000_0F0F, 5'd0, 32'h0000_0FFF, 1'b0, 1);
    run_op("nor",      4'b0101, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1);
    run_op("illegal",  4'b0011, 32'h1234, 32'h5678, 5'd0, 32'h0, 1'b1, 1);
    run_op("illegal_f", 4'b1111, 32'h1, 32'h1, 5'd0, 32'h0, 1'b1, 1);

    // Shifts, including zero amount and the full 31-bit case.
    send(4'b1010, 32'h4, 32'h8000_0000, 5'd0, 32'hF800_0000, 1'b0, acc, stalls);
    wait_valid(acc, lat, low);
    check("sra4_latency", lat, 32'd5);
    check("sra4_inready_low", low, 32'd4);
    run_op("slli0",   4'b0100, 32'h7, 32'h1234, 5'd0, 32'h1234, 1'b0, 1);
    run_op("slli3",   4'b0100, 32'h0, 32'h1, 5'd3, 32'h8, 1'b0, 4);
    run_op("sll31",   4'b1000, 32'd31, 32'h1, 5'd0, 32'h8000_0000, 1'b0, 32);
    run_op("srl4",    4'b1001, 32'h4, 32'h8000_0000, 5'd0, 32'h0800_0000, 1'b0, 5);
    run_op("sra0",    4'b1010, 32'h20, 32'h8000_0000, 5'd0, 32'h8000_0000, 1'b0, 1);

    // Output stall: result held while OutReady=0, bus changes ignored.
    OutReady = 1'b0;
    send(4'b0010, 32'h2, 32'h3, 5'd0, 32'h5, 1'b0, acc, stalls);
    wait_valid(acc, lat, low);
    check("hold_add_latency", lat, 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, OutValid}, 32'd1);
      check("hold_result", Result, 32'h5);
      check("hold_inready", {31'd0, InReady}, 32'd0);
      @(posedge clk); #1;
      ALUControl = 4'b0001; SrcA = $urandom; SrcB = $urandom;
    end
    OutReady = 1'b1;
    send(4'b0001, 32'h0000_00F0, 32'h0000_000F, 5'd0, 32'h0000_00FF, 1'b0, acc, stalls);
    check("release_accept_stalls", stalls, 32'd0);
    wait_valid(acc, lat, low);
    check("release_or_latency", lat, 32'd1);

    // Back-to-back issue from DONE.
    send(4'b0010, 32'h4, 32'h6, 5'd0, 32'hA, 1'b0, acc, stalls);
    send(4'b0110, 32'hA, 32'h3, 5'd0, 32'h7, 1'b0, acc2, stalls);
    check("b2b_gap", acc2 - acc, 32'd1);
    wait_valid(acc2, lat, low);
    check("b2b_sub_latency", lat, 32'd1);
    send(4'b0110, 32'h1, 32'h1, 5'd0, 32'h0, 1'b0, acc, stalls);
    send(4'b1000, 32'h2, 32'h3, 5'd0, 32'hC, 1'b0, acc2, stalls);
    check("b2b_shift_gap", acc2 - acc, 32'd1);
    wait_valid(acc2, lat, low);
    check("b2b_sll_latency", lat, 32'd3);

    // Reset in the middle of a 20-bit shift (counter at 10).
    send(4'b1000, 32'd20, 32'h1, 5'd0, 32'h0010_0000, 1'b0, acc, stalls);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();  // the abandoned shift must never produce an output
    #1;
    check("midrst_outvalid", {31'd0, OutValid}, 32'd0);
    check("midrst_result", Result, 32'd0);
    check("midrst_state", {30'd0, dbg_state}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_inready", {31'd0, InReady}, 32'd1);
    vcount = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (OutValid) vcount++;
    end
    check("midrst_no_stale", vcount, 32'd0);
    @(posedge clk); #1;
    run_op("post_rst_add", 4'b0010, 32'h1, 32'h1, 5'd0, 32'h2, 1'b0, 1);

    repeat (2) @(posedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port InValid  input  1  upstream operation presented.
REQ-005 SHALL have port InReady  output  1  unit can accept an operation this cycle.
REQ-006 SHALL have port ALUControl  input  4  operation code from the ALU decoder.
REQ-007 SHALL have port SrcA  input  WIDTH  operand A; SrcA[4:0] is the shift amount for variable shifts.
REQ-008 SHALL have port SrcB  input  WIDTH  operand B; value shifted by all shift ops.
REQ-009 SHALL have port Shamt  input  5  immediate shift amount for SLLI.
REQ-010 SHALL have port OutValid  output  1  Result/Zero/IllegalOp valid.
REQ-011 SHALL have port OutReady  input  1  downstream accepts result.
REQ-012 SHALL have port Result  output  WIDTH  operation result.
REQ-013 SHALL have port Zero  output  1  Result equals 0.
REQ-014 SHALL have port IllegalOp  output  1  accepted code was not in the REQ-016 table.

Function
REQ-015 SHALL accept an operation (capture ALUControl, SrcA, SrcB, Shamt) on a rising edge where InValid and InReady are both 1.
REQ-016 SHALL decode: 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 0111 SLT; 0101 NOR; 0100 SLLI (SrcB<<Shamt); 1000 SLL (SrcB<<SrcA[4:0]); 1001 SRL logical; 1010 SRA arithmetic.
REQ-017 SHALL compute ADD/SUB modulo 2^32, no overflow flag; SLT SHALL be signed two's-complement, result 32'h1 or 32'h0.
REQ-018 SHALL, for any other code, produce Result 0, Zero 1, IllegalOp 1, latency 1.
REQ-019 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-020 SHALL move IDLE->DONE on accept of a non-shift op or a shift with amount 0; Result registered, OutValid high the next cycle (latency 1).
REQ-021 SHALL move IDLE->SHIFT on accept of a shift with amount n>0, loading SrcB into a shift register and n into a down-counter.
REQ-022 SHALL in SHIFT shift exactly one bit per cycle (SRA replicates bit 31, SRL/SLL fill 0), decrement counter, and move to DONE when counter reaches 0; OutValid asserts n+1 cycles after accept.
REQ-023 SHALL in DONE hold Result, Zero, IllegalOp, OutValid=1 stable until OutReady=1.
REQ-024 SHALL drive InReady = (state==IDLE) or (state==DONE and OutReady); InReady SHALL be 0 in SHIFT.
REQ-025 SHALL, on DONE with OutReady=1 and InValid=1, accept the new op in the same cycle (back-to-back, no bubble) and go to DONE or SHIFT per REQ-020/021.
REQ-026 SHALL, on DONE with OutReady=1 and InValid=0, return to IDLE with OutValid=0 next cycle.
REQ-027 SHALL ignore ALUControl/SrcA/SrcB/Shamt changes while not accepting.
REQ-028 SHALL derive Zero from the registered Result only.

Reset
REQ-029 SHALL on rst_n=0 immediately force state IDLE, OutValid 0, Result 0, Zero 0, IllegalOp 0, counter 0, independent of clk.
REQ-030 SHALL abandon any in-flight shift on reset; no result is produced for it.
REQ-031 SHALL drive InReady 1 from the first cycle after rst_n deasserts.

Verification
REQ-032 ADD A=32'hFFFFFFFF, B=1, OutReady=1 -> next cycle OutValid=1, Result=0, Zero=1, IllegalOp=0.
REQ-033 SLT A=32'hFFFFFFFE (-2), B=1 -> Result=1; SUB A=5, B=5 -> Result=0, Zero=1.
REQ-034 SRA code 1010, A=4, B=32'h80000000 -> InReady=0 for 4 cycles, OutValid at accept+5, Result=32'hF8000000.
REQ-035 SLLI Shamt=0, B=32'h1234 -> latency 1, Result=32'h1234; SLL A=31, B=1 -> latency 32, Result=32'h80000000.
REQ-036 OutReady=0 for 3 cycles after ADD result, then 1 with new OR op at InValid -> Result held 3 cycles, OR accepted on the release edge, its result next cycle; code 0011 -> Result=0, IllegalOp=1.
REQ-037 Assert rst_n=0 mid-SHIFT (counter=10) -> OutValid=0, Result=0 immediately; after release InReady=1, no stale result emitted.
